// File: rtl/h_u_serial_sub12.sv
// h_u_serial_sub12
// Serial unsigned ripple-borrow subtractor: computes a - b for two N-bit
// unsigned operands, D bits per clock, through a chain of D full-subtractor
// cells and a registered borrow between digits.
//
// Parameters:
//   N  operand width (must be a multiple of D)
//   D  digit width, bits processed per cycle (1..N)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a/b valid
//   in_ready   accepting operands (IDLE only)
//   a, b       minuend, subtrahend (unsigned, N bits)
//   out_valid  out holds a completed result (DONE only)
//   out_ready  consumer accepts out
//   out        {final borrow, difference} = (a - b) mod 2^(N+1)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are decoded from the state register
// only, so neither depends combinationally on in_valid or out_ready.
// The FSM state is held in state_q for checker binding.
module h_u_serial_sub12 #(
  parameter int N = 12,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out
);

  localparam int DIGITS = N / D;
  localparam int CW     = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   diff_sh;
  logic           borrow_q;
  logic [CW-1:0]  cnt_q;
  logic [N:0]     out_q;

  logic [D-1:0]   dig;
  logic           bout;
  logic [N-1:0]   dig_ext;
  logic [N-1:0]   diff_next;
  logic           last_digit;

  // Chain of D full-subtractor cells over the low D operand bits.
  always_comb begin
    logic bc;
    bc  = borrow_q;
    dig = '0;
    for (int i = 0; i < D; i++) begin
      dig[i] = a_sh[i] ^ b_sh[i] ^ bc;
      bc     = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & bc);
    end
    bout = bc;
  end

  // New digit enters the result register from the MSB side; after N/D
  // digits the first digit has reached bit 0. Written as shifts so the
  // D == N case needs no empty slice.
  always_comb begin
    dig_ext          = '0;
    dig_ext[D-1:0]   = dig;
    diff_next        = (diff_sh >> D) | (dig_ext << (N - D));
  end

  assign last_digit = (cnt_q == CW'(DIGITS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)   state_d = RUN;
      RUN:  if (last_digit) state_d = DONE;
      DONE: if (out_ready)  state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            diff_sh  <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> D;
          b_sh     <= b_sh >> D;
          diff_sh  <= diff_next;
          borrow_q <= bout;
          cnt_q    <= cnt_q + 1'b1;
          // out only changes here, so it stays put through DONE and after
          // the handshake until the next completion.
          if (last_digit) begin
            out_q <= {bout, diff_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
